// File: rtl/mdu_pkg.sv
// Shared types and sizing for the RV32M iterative divider.
package mdu_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = XLEN;
  localparam int CNT_W     = $clog2(DIV_STEPS + 1);

  // Encodings match funct3[1:0] of the RV32M divide instructions.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_if.sv
// Execute-stage handshake between the pipeline and the divider.
interface mdu_div_if;
  import mdu_pkg::*;

  logic            start;
  div_op_e         op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in, kill,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step of the radix-2 divider.
module div_step
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor always holds, so the trial fits in XLEN+1 bits and its MSB is the sign.
  always_comb begin
    shifted   = {rem, quot[XLEN-1]};
    trial     = shifted - {1'b0, divisor};
    rem_next  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quot_next = {quot[XLEN-2:0], ~trial[XLEN]};
  end

endmodule

// File: rtl/mdu_div.sv
// RV32M DIV/DIVU/REM/REMU: FSM, step counter, sign handling and result registers.
module mdu_div
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mdu_div_if.slave   bus
);

  div_state_e      state, state_next;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] rem_q, quot_q, divisor_q;
  logic [XLEN-1:0] rem_nx, quot_nx;
  div_op_e         op_q;
  logic            sign_a, sign_b;
  logic [4:0]      rd_lat;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            accept, is_signed, a_neg, b_neg, div_zero, overflow;
  logic            last_step, op_is_rem;
  logic            done_c;
  logic [XLEN-1:0] q_fix, r_fix, final_val, special_val;

  div_step u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (rem_nx),
    .quot_next (quot_nx)
  );

  always_comb begin
    accept      = (state == IDLE) && bus.start && !bus.kill;
    is_signed   = (bus.op == OP_DIV) || (bus.op == OP_REM);
    op_is_rem   = (bus.op == OP_REM) || (bus.op == OP_REMU);
    a_neg       = is_signed && bus.rs1_val[XLEN-1];
    b_neg       = is_signed && bus.rs2_val[XLEN-1];
    div_zero    = (bus.rs2_val == '0);
    overflow    = is_signed && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
    special_val = '0;
    if (div_zero)
      special_val = op_is_rem ? bus.rs1_val : '1;
    else if (overflow)
      special_val = op_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    last_step   = (state == CALC) && (count == CNT_W'(1));
    q_fix       = (sign_a ^ sign_b) ? -quot_nx : quot_nx;
    r_fix       = sign_a ? -rem_nx : rem_nx;
    final_val   = ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    case (state)
      IDLE: if (accept) state_next = (div_zero || overflow) ? DONE : CALC;
      CALC: begin
        if (bus.kill)       state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        done_c     = !bus.kill;
      end
      default: state_next = IDLE;
    endcase
  end

  // Special cases skip CALC and write the result straight away on the start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      op_q      <= OP_DIV;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      rd_lat    <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      rd_lat <= bus.rd_in;
      sign_a <= a_neg;
      sign_b <= b_neg;
      if (div_zero || overflow) begin
        result_q <= special_val;
        rd_out_q <= bus.rd_in;
      end else begin
        rem_q     <= '0;
        quot_q    <= abs_val(bus.rs1_val, a_neg);
        divisor_q <= abs_val(bus.rs2_val, b_neg);
        count     <= CNT_W'(DIV_STEPS);
      end
    end else if ((state == CALC) && !bus.kill) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      count  <= count - CNT_W'(1);
      if (last_step) begin
        result_q <= final_val;
        rd_out_q <= rd_lat;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
